// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the lsu_mem_ctrl load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam int c_DATA_W = 64;
    localparam int c_ADDR_W = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_ROM      = 2'd2,
        FLT_RANGE    = 2'd3
    } fault_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    // Low-order byte-address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input size_e size);
        case (size)
            SZ_B:    align_mask = 3'b000;
            SZ_H:    align_mask = 3'b001;
            SZ_W:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [c_DATA_W-1:0] lane_mask(input size_e size);
        case (size)
            SZ_B:    lane_mask = 64'h0000_0000_0000_00FF;
            SZ_H:    lane_mask = 64'h0000_0000_0000_FFFF;
            SZ_W:    lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane extract/extend for loads and lane merge
//               for read-modify-write stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [c_DATA_W-1:0] i_rd_data,
    input  logic [c_DATA_W-1:0] i_wdata,
    input  logic [2:0]          i_offset,
    input  size_e               i_size,
    input  logic                i_unsigned,
    output logic [c_DATA_W-1:0] o_load_data,
    output logic [c_DATA_W-1:0] o_merged
);

    logic [5:0]          w_shamt;
    logic [c_DATA_W-1:0] w_mask;
    logic [c_DATA_W-1:0] w_lane;

    assign w_shamt = {i_offset, 3'b000};
    assign w_mask  = lane_mask(i_size);
    assign w_lane  = (i_rd_data >> w_shamt) & w_mask;

    always_comb begin
        o_load_data = w_lane;
        if (!i_unsigned) begin
            case (i_size)
                SZ_B:    o_load_data = {{56{w_lane[7]}},  w_lane[7:0]};
                SZ_H:    o_load_data = {{48{w_lane[15]}}, w_lane[15:0]};
                SZ_W:    o_load_data = {{32{w_lane[31]}}, w_lane[31:0]};
                default: o_load_data = w_lane;
            endcase
        end
    end

    // Only aligned accesses reach here, so the shifted lane never wraps past bit 63.
    assign o_merged = (i_rd_data & ~(w_mask << w_shamt)) | ((i_wdata & w_mask) << w_shamt);

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store controller converting byte/half/word/double core
//               accesses into whole-word memory cycles (RMW for sub-word
//               stores). Optional ROM store guard: LSU_ROM_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = 256,
    parameter int ROM_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [c_ADDR_W-1:0] req_addr,
    input  logic [c_DATA_W-1:0] req_wdata,
    output logic                resp_valid,
    output logic [c_DATA_W-1:0] resp_rdata,
    output logic [1:0]          resp_fault,
    output logic [c_ADDR_W-1:0] mem_addr,
    output logic [c_DATA_W-1:0] mem_wr_data,
    output logic                mem_wr_enable,
    output logic                mem_rd_enable,
    input  logic [c_DATA_W-1:0] mem_rd_data
);

    localparam logic [28:0] c_MEM_WORDS = 29'(MEM_SIZE);
`ifdef LSU_ROM_GUARD_EN
    localparam logic [28:0] c_ROM_WORDS = 29'(ROM_SIZE);
`endif

    state_e               r_state;
    state_e               w_next;
    logic                 r_we;
    size_e                r_size;
    logic                 r_unsigned;
    logic [c_ADDR_W-1:0]  r_addr;
    logic [c_DATA_W-1:0]  r_wdata;
    fault_e               r_fault;
    logic [c_DATA_W-1:0]  r_rdata;
    logic [c_DATA_W-1:0]  r_merged;

    fault_e               w_fault;
    logic                 w_accept;
    logic [c_ADDR_W-1:0]  w_word_addr;
    logic [c_DATA_W-1:0]  w_load_data;
    logic [c_DATA_W-1:0]  w_merged;

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_word_addr = {r_addr[31:3], 3'b000};

    // Checks evaluated on the live request; earlier checks take priority.
    always_comb begin
        w_fault = FLT_NONE;
        if (|(req_addr[2:0] & align_mask(size_e'(req_size)))) begin
            w_fault = FLT_MISALIGN;
        end else if (req_addr[31:3] >= c_MEM_WORDS) begin
            w_fault = FLT_RANGE;
        end
`ifdef LSU_ROM_GUARD_EN
        else if (req_we && (req_addr[31:3] < c_ROM_WORDS)) begin
            w_fault = FLT_ROM;
        end
`endif
    end

    lsu_align u_align (
        .i_rd_data   (mem_rd_data),
        .i_wdata     (r_wdata),
        .i_offset    (r_addr[2:0]),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_rd_enable = 1'b0;
        mem_wr_enable = 1'b0;
        mem_addr      = '0;
        mem_wr_data   = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_fault != FLT_NONE) begin
                        w_next = ST_FAULT;
                    end else if (!req_we) begin
                        w_next = ST_LOAD;
                    end else if (size_e'(req_size) == SZ_D) begin
                        w_next = ST_STORE;
                    end else begin
                        w_next = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                mem_rd_enable = 1'b1;
                mem_addr      = w_word_addr;
                w_next        = ST_RESP;
            end
            ST_STORE: begin
                mem_wr_enable = 1'b1;
                mem_addr      = w_word_addr;
                mem_wr_data   = r_wdata;
                w_next        = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_rd_enable = 1'b1;
                mem_addr      = w_word_addr;
                w_next        = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_wr_enable = 1'b1;
                mem_addr      = w_word_addr;
                mem_wr_data   = r_merged;
                w_next        = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                w_next     = ST_IDLE;
            end
            ST_FAULT: begin
                resp_valid = 1'b1;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_fault    <= FLT_NONE;
            r_rdata    <= '0;
            r_merged   <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= size_e'(req_size);
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_fault    <= w_fault;
            end
            if (r_state == ST_LOAD) begin
                r_rdata <= w_load_data;
            end
            if (r_state == ST_RMW_RD) begin
                r_merged <= w_merged;
            end
        end
    end

    // Stores share the RESP state, so the load result is masked by the latched direction.
    assign resp_rdata = (r_state == ST_RESP && !r_we) ? r_rdata : '0;
    assign resp_fault = (r_state == ST_FAULT) ? r_fault : FLT_NONE;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Directed self-checking bench for lsu_mem_ctrl with a 256-word
//               behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic [31:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic        mem_wr_enable;
    logic        mem_rd_enable;
    logic [63:0] mem_rd_data;

    logic [63:0] mem [0:255];
    logic        preload;

    int          n_checks;
    int          n_pass;
    int          g_lat;
    int          g_nrd;
    int          g_nwr;
    int          g_both;
    int          g_wr_k;
    logic [63:0] g_rdata;
    logic [1:0]  g_flt;

    lsu_mem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_enable (mem_wr_enable),
        .mem_rd_enable (mem_rd_enable),
        .mem_rd_data   (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr[10:3]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'h0;
            mem[20] <= 64'h8877_6655_4433_2211;
            mem[1]  <= 64'h0101_0101_0101_0101;
        end else if (mem_wr_enable) begin
            mem[mem_addr[10:3]] <= mem_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request and observes every cycle until the response (or a timeout).
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [63:0] wd);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
        g_lat = 0; g_nrd = 0; g_nwr = 0; g_both = 0; g_wr_k = 0;
        g_rdata = '1; g_flt = '1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_rd_enable) g_nrd++;
            if (mem_wr_enable) begin
                g_nwr++;
                if (g_wr_k == 0) g_wr_k = k;
            end
            if (mem_rd_enable && mem_wr_enable) g_both++;
            if (resp_valid) begin
                g_lat   = k;
                g_rdata = resp_rdata;
                g_flt   = resp_fault;
                break;
            end
        end
    endtask

    initial begin
        int nw;
        int nresp;
        n_checks = 0; n_pass = 0;
        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready",  {63'b0, req_ready},     64'd1);
        chk("rst_rvalid", {63'b0, resp_valid},    64'd0);
        chk("rst_rdata",  resp_rdata,             64'd0);
        chk("rst_fault",  {62'b0, resp_fault},    64'd0);
        chk("rst_strobe", {62'b0, mem_rd_enable, mem_wr_enable}, 64'd0);
        chk("rst_maddr",  {32'b0, mem_addr},      64'd0);
        rst = 1'b0; preload = 1'b0;

        do_req(1'b0, 2'd0, 1'b0, 32'hA7, '0);
        chk("ldb_s_data", g_rdata, 64'hFFFF_FFFF_FFFF_FF88);
        chk("ldb_s_flt",  {62'b0, g_flt}, 64'd0);
        chk("ldb_s_lat",  64'(g_lat), 64'd2);
        chk("ldb_s_nrd",  64'(g_nrd), 64'd1);
        chk("ldb_s_nwr",  64'(g_nwr), 64'd0);

        do_req(1'b0, 2'd1, 1'b1, 32'hA6, '0);
        chk("ldh_u_data", g_rdata, 64'h0000_0000_0000_8877);
        do_req(1'b0, 2'd2, 1'b0, 32'hA0, '0);
        chk("ldw_s_pos",  g_rdata, 64'h0000_0000_4433_2211);
        do_req(1'b0, 2'd2, 1'b0, 32'hA4, '0);
        chk("ldw_s_neg",  g_rdata, 64'hFFFF_FFFF_8877_6655);
        do_req(1'b0, 2'd3, 1'b0, 32'hA0, '0);
        chk("ldd_data",   g_rdata, 64'h8877_6655_4433_2211);

        do_req(1'b1, 2'd0, 1'b0, 32'hA3, 64'h1122_3344_5566_77AB);
        chk("stb_lat",    64'(g_lat), 64'd3);
        chk("stb_nrd",    64'(g_nrd), 64'd1);
        chk("stb_nwr",    64'(g_nwr), 64'd1);
        chk("stb_both",   64'(g_both), 64'd0);
        chk("stb_rdata",  g_rdata, 64'd0);
        chk("stb_mem",    mem[20], 64'h8877_6655_AB33_2211);
        do_req(1'b0, 2'd0, 1'b1, 32'hA3, '0);
        chk("stb_rdback", g_rdata, 64'h0000_0000_0000_00AB);

        do_req(1'b1, 2'd1, 1'b0, 32'h1FE, 64'h1234_5678_DEAD_BEEF);
        chk("sth_mem",    mem[63], 64'hBEEF_0000_0000_0000);

        do_req(1'b0, 2'd1, 1'b0, 32'hA1, '0);
        chk("mis_flt",    {62'b0, g_flt}, 64'd1);
        chk("mis_lat",    64'(g_lat), 64'd1);
        chk("mis_strobe", 64'(g_nrd + g_nwr), 64'd0);
        chk("mis_rdata",  g_rdata, 64'd0);

        do_req(1'b0, 2'd3, 1'b0, 32'h800, '0);
        chk("rng_flt",    {62'b0, g_flt}, 64'd3);
        chk("rng_strobe", 64'(g_nrd + g_nwr), 64'd0);
        do_req(1'b0, 2'd1, 1'b0, 32'h801, '0);
        chk("prio_flt",   {62'b0, g_flt}, 64'd1);

        do_req(1'b1, 2'd3, 1'b0, 32'h08, 64'hCAFE_F00D_1234_5678);
`ifdef LSU_ROM_GUARD_EN
        chk("rom_flt",    {62'b0, g_flt}, 64'd2);
        chk("rom_lat",    64'(g_lat), 64'd1);
        chk("rom_nwr",    64'(g_nwr), 64'd0);
        chk("rom_mem",    mem[1], 64'h0101_0101_0101_0101);
`else
        chk("std_flt",    {62'b0, g_flt}, 64'd0);
        chk("std_wr_k",   64'(g_wr_k), 64'd1);
        chk("std_lat",    64'(g_lat), 64'd2);
        chk("std_mem",    mem[1], 64'hCAFE_F00D_1234_5678);
`endif

        // Reset lands while the controller sits in RMW_RD.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'hA0; req_wdata = 64'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rr_in_rmwrd", {63'b0, mem_rd_enable}, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rr_ready_async", {63'b0, req_ready}, 64'd1);
        nw = 0; nresp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_wr_enable) nw++;
            if (resp_valid) nresp++;
            if (k == 2) rst = 1'b0;
        end
        chk("rr_nwr",    64'(nw), 64'd0);
        chk("rr_nresp",  64'(nresp), 64'd0);
        chk("rr_ready",  {63'b0, req_ready}, 64'd1);
        chk("rr_mem",    mem[20], 64'h8877_6655_AB33_2211);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
